// File: rtl/pcie_traffic_gen.sv
// Traffic generator/checker for the PCIe QoS interconnect: pushes tagged words, drains the
// destination FIFOs and checks per-destination order and routing. Define TG_LFSR_EN for LFSR routing.
module pcie_traffic_gen #(
    parameter int BW      = 6,
    parameter int NDEST   = 2,
    parameter int DSW     = 1,
    parameter int TIMEOUT = 255
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                start_i,
    input  logic [7:0]          num_pkts_i,
    input  logic                mode_i,
    input  logic [7:0]          lfsr_seed_i,
    input  logic                main_full_i,
    output logic                main_wr_o,
    output logic [BW-1:0]       main_data_o,
    input  logic [NDEST-1:0]    dst_empty_i,
    input  logic [NDEST-1:0]    dst_error_i,
    output logic [NDEST-1:0]    dst_rd_o,
    input  logic [NDEST*BW-1:0] dst_data_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                pass_o,
    output logic                timed_out_o,
    output logic [7:0]          err_cnt_o,
    output logic [7:0]          rx_cnt_o
);
    localparam int PW  = BW - DSW;
    localparam int IDW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, SEND, DRAIN, DONE} state_t;

    state_t           state_q, state_d;
    logic [7:0]       npkts_q, npkts_d;
    logic [7:0]       tx_cnt_q, tx_cnt_d;
    logic [7:0]       rx_cnt_q, rx_cnt_d;
    logic [7:0]       err_cnt_q, err_cnt_d;
    logic [IDW-1:0]   idle_q, idle_d;
    logic             timed_out_q, timed_out_d;
    logic [DSW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]    tx_seq_q [NDEST];
    logic [PW-1:0]    tx_seq_d [NDEST];
    logic [PW-1:0]    rx_seq_q [NDEST];
    logic [PW-1:0]    rx_seq_d [NDEST];
    logic [NDEST-1:0] dst_rd_q, dst_rd_d;
    logic [NDEST-1:0] chk_vld_q, chk_vld_d;

    logic             busy;
    logic             push;
    logic [DSW-1:0]   cur_dest;
    logic [BW-1:0]    cur_word;
    logic [7:0]       rx_inc;
    logic [7:0]       err_inc;

    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

`ifdef TG_LFSR_EN
    logic [7:0] lfsr_q, lfsr_d;
    logic       mode_q, mode_d;

    // Fibonacci LFSR, taps 8,6,5,4
    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    assign cur_dest = mode_q ? lfsr_q[DSW-1:0] : rr_ptr_q;
`else
    logic unused_cfg;
    assign unused_cfg = ^{mode_i, lfsr_seed_i};
    assign cur_dest   = rr_ptr_q;
`endif

    assign busy     = (state_q == SEND) || (state_q == DRAIN);
    assign cur_word = {cur_dest, tx_seq_q[cur_dest]};

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            npkts_q     <= '0;
            tx_cnt_q    <= '0;
            rx_cnt_q    <= '0;
            err_cnt_q   <= '0;
            idle_q      <= '0;
            timed_out_q <= 1'b0;
            rr_ptr_q    <= '0;
            dst_rd_q    <= '0;
            chk_vld_q   <= '0;
            for (int d = 0; d < NDEST; d++) begin
                tx_seq_q[d] <= '0;
                rx_seq_q[d] <= '0;
            end
`ifdef TG_LFSR_EN
            lfsr_q      <= 8'h01;
            mode_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            npkts_q     <= npkts_d;
            tx_cnt_q    <= tx_cnt_d;
            rx_cnt_q    <= rx_cnt_d;
            err_cnt_q   <= err_cnt_d;
            idle_q      <= idle_d;
            timed_out_q <= timed_out_d;
            rr_ptr_q    <= rr_ptr_d;
            dst_rd_q    <= dst_rd_d;
            chk_vld_q   <= chk_vld_d;
            for (int d = 0; d < NDEST; d++) begin
                tx_seq_q[d] <= tx_seq_d[d];
                rx_seq_q[d] <= rx_seq_d[d];
            end
`ifdef TG_LFSR_EN
            lfsr_q      <= lfsr_d;
            mode_q      <= mode_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        npkts_d     = npkts_q;
        tx_cnt_d    = tx_cnt_q;
        idle_d      = idle_q;
        timed_out_d = timed_out_q;
        rr_ptr_d    = rr_ptr_q;
`ifdef TG_LFSR_EN
        lfsr_d      = lfsr_q;
        mode_d      = mode_q;
`endif
        for (int d = 0; d < NDEST; d++) begin
            tx_seq_d[d] = tx_seq_q[d];
            rx_seq_d[d] = rx_seq_q[d];
        end
        push        = 1'b0;
        main_wr_o   = 1'b0;
        main_data_o = '0;
        rx_inc      = '0;
        err_inc     = '0;

        // Data on a destination is checked one cycle after its registered read strobe.
        if (busy) begin
            for (int d = 0; d < NDEST; d++) begin
                if (chk_vld_q[d]) begin
                    rx_seq_d[d] = rx_seq_q[d] + 1'b1;
                    rx_inc      = rx_inc + 8'd1;
                    if (dst_data_i[d*BW +: BW] != {DSW'(d), rx_seq_q[d]}) begin
                        err_inc = err_inc + 8'd1;
                    end
                end
            end
        end
        rx_cnt_d  = rx_cnt_q + rx_inc;
        err_cnt_d = sat_add8(err_cnt_q, err_inc);

        case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    npkts_d     = num_pkts_i;
                    tx_cnt_d    = '0;
                    rx_cnt_d    = '0;
                    err_cnt_d   = '0;
                    idle_d      = '0;
                    timed_out_d = 1'b0;
                    rr_ptr_d    = '0;
                    for (int d = 0; d < NDEST; d++) begin
                        tx_seq_d[d] = '0;
                        rx_seq_d[d] = '0;
                    end
`ifdef TG_LFSR_EN
                    lfsr_d      = (lfsr_seed_i == 8'h00) ? 8'h01 : lfsr_seed_i;
                    mode_d      = mode_i;
`endif
                    state_d     = (num_pkts_i == 8'd0) ? DONE : SEND;
                end
            end
            SEND: begin
                main_data_o = cur_word;
                if (!main_full_i) begin
                    main_wr_o = 1'b1;
                    push      = 1'b1;
                    tx_cnt_d  = tx_cnt_q + 8'd1;
                    if (tx_cnt_d == npkts_q) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (rx_cnt_d == npkts_q) begin
                    state_d = DONE;
                end else if (rx_inc != 8'd0) begin
                    idle_d = '0;
                end else if (idle_q == IDW'(TIMEOUT - 1)) begin
                    timed_out_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    idle_d = idle_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (push) begin
            rr_ptr_d = (rr_ptr_q == DSW'(NDEST - 1)) ? '0 : rr_ptr_q + 1'b1;
`ifdef TG_LFSR_EN
            lfsr_d   = lfsr_step(lfsr_q);
`endif
            for (int d = 0; d < NDEST; d++) begin
                if (cur_dest == DSW'(d)) begin
                    tx_seq_d[d] = tx_seq_q[d] + 1'b1;
                end
            end
        end

        // Reads issue only while the run is live; errored destinations are never touched.
        if ((state_d == SEND) || (state_d == DRAIN)) begin
            dst_rd_d = ~dst_empty_i & ~dst_error_i;
        end else begin
            dst_rd_d = '0;
        end
        chk_vld_d = dst_rd_q;
    end

    assign dst_rd_o    = dst_rd_q;
    assign busy_o      = busy;
    assign done_o      = (state_q == DONE);
    assign pass_o      = (state_q == DONE) && (err_cnt_q == 8'd0) && !timed_out_q;
    assign timed_out_o = timed_out_q;
    assign err_cnt_o   = err_cnt_q;
    assign rx_cnt_o    = rx_cnt_q;

endmodule
